// File: rtl/counter_pkg.sv
`default_nettype none
// counter_pkg: shared direction constants and sizing helper for the up/down counter.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Ceiling log2; returns 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enable_prescaler.sv
`default_nettype none
// enable_prescaler: divides qualifying enable cycles by PRESCALE, emitting a one-cycle tick.
module enable_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_cnt;
  logic          at_last;

  assign at_last = (presc_cnt == LAST);
  assign tick    = enable && at_last;

  // Holds while enable is low so partial progress toward a step is kept.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      presc_cnt <= '0;
    end else if (enable) begin
      presc_cnt <= at_last ? '0 : presc_cnt + PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mod_updown_counter.sv
`default_nettype none
// mod_updown_counter: parametrised modulo up/down counter with load, prescaled enable and tc/wrap flags.
// Define COUNTER_SATURATE_EN to hold at the limits instead of wrapping.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
  parameter int              PRESCALE  = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             wrap_pulse
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VALUE);

  logic             step;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

  enable_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (load),
    .enable  (enable),
    .tick    (step)
  );

  assign at_max       = (count_out == MAX);
  assign at_zero      = (count_out == '0);
  assign tc           = (up_down == DIR_UP) ? at_max : at_zero;
  assign load_clamped = (load_value > MAX) ? MAX : load_value;

  always_comb begin
    next_count = count_out;
    next_wrap  = 1'b0;
    if (up_down == DIR_UP) begin
      if (at_max) begin
`ifdef COUNTER_SATURATE_EN
        next_count = MAX;
`else
        next_count = '0;
        next_wrap  = 1'b1;
`endif
      end else begin
        next_count = count_out + WIDTH'(1);
`ifdef COUNTER_SATURATE_EN
        next_wrap  = (next_count == MAX);
`endif
      end
    end else begin
      if (at_zero) begin
`ifdef COUNTER_SATURATE_EN
        next_count = '0;
`else
        next_count = MAX;
        next_wrap  = 1'b1;
`endif
      end else begin
        next_count = count_out - WIDTH'(1);
`ifdef COUNTER_SATURATE_EN
        next_wrap  = (next_count == '0);
`endif
      end
    end
  end

  // wrap_pulse drops on every edge that is not itself a wrapping step.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_out  <= '0;
      wrap_pulse <= 1'b0;
    end else if (load) begin
      count_out  <= load_clamped;
      wrap_pulse <= 1'b0;
    end else if (step) begin
      count_out  <= next_count;
      wrap_pulse <= next_wrap;
    end else begin
      wrap_pulse <= 1'b0;
    end
  end

endmodule
`default_nettype wire
